// File: rtl/eth_rx_pkt_writer_if.sv
// Port bundle of the RX packet writer: MAC byte stream in, BRAM port B out,
// ping-pong buffer status and consumer release handshake.
interface eth_rx_pkt_writer_if;
    logic [7:0]  rx_d_in;
    logic        rx_valid_in;
    logic        rx_last_in;
    logic        rx_err_in;
    logic        bram_en_out;
    logic        bram_we_out;
    logic [12:0] bram_addr_out;
    logic [7:0]  bram_d_out;
    logic [1:0]  full_out;
    logic [12:0] len0_out;
    logic [12:0] len1_out;
    logic [1:0]  release_in;
    logic [15:0] drop_cnt_out;

    modport master (
        output rx_d_in, rx_valid_in, rx_last_in, rx_err_in, release_in,
        input  bram_en_out, bram_we_out, bram_addr_out, bram_d_out,
        input  full_out, len0_out, len1_out, drop_cnt_out
    );

    modport slave (
        input  rx_d_in, rx_valid_in, rx_last_in, rx_err_in, release_in,
        output bram_en_out, bram_we_out, bram_addr_out, bram_d_out,
        output full_out, len0_out, len1_out, drop_cnt_out
    );
endinterface

// File: rtl/eth_rx_pkt_writer.sv
// Writes MAC RX frames into one half of a ping-pong 8KB packet BRAM, publishes
// committed halves/lengths to the consumer and counts discarded frames.
module eth_rx_pkt_writer #(
    parameter int unsigned HALF_BYTES = 4096,
    parameter int unsigned MIN_LEN    = 14
) (
    input  logic               clk_in,
    input  logic               rst_in,
    eth_rx_pkt_writer_if.slave bus
);

    typedef enum logic [1:0] {SYNC, IDLE, RECV, DROP} state_e;

    state_e      state_q, state_d;
    logic [12:0] count_q, count_d;
    logic        wr_half_q, wr_half_d;
    logic [1:0]  full_q, full_d;
    logic [12:0] len0_q, len0_d, len1_q, len1_d;
    logic [15:0] drop_q, drop_d;
    logic        we_q, we_d;
    logic [12:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        commit_q, commit_d;
    logic        commit_half_q, commit_half_d;
    logic [12:0] commit_len_q, commit_len_d;

    logic        vlast;
    logic        in_frame;
    logic [12:0] cur_cnt;
    logic [12:0] next_cnt;
    logic        drop_inc;

    assign vlast    = bus.rx_valid_in & bus.rx_last_in;
    assign cur_cnt  = (state_q == IDLE) ? '0 : count_q;
    assign next_cnt = cur_cnt + 13'd1;
    assign in_frame = bus.rx_valid_in &
                      (((state_q == IDLE) && !full_q[wr_half_q]) || (state_q == RECV));

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        wr_half_d     = wr_half_q;
        we_d          = 1'b0;
        addr_d        = addr_q;
        data_d        = data_q;
        commit_d      = 1'b0;
        commit_half_d = commit_half_q;
        commit_len_d  = commit_len_q;
        drop_inc      = 1'b0;

        if (in_frame) begin
            if (bus.rx_err_in || (cur_cnt == 13'(HALF_BYTES))) begin
                state_d  = bus.rx_last_in ? IDLE : DROP;
                drop_inc = bus.rx_last_in;
            end else begin
                we_d    = 1'b1;
                addr_d  = {wr_half_q, cur_cnt[11:0]};
                data_d  = bus.rx_d_in;
                count_d = next_cnt;
                state_d = RECV;
                if (bus.rx_last_in) begin
                    state_d = IDLE;
                    if (next_cnt >= 13'(MIN_LEN)) begin
                        // wr_half flips a cycle before full[] so a back-to-back
                        // frame already targets the other half.
                        commit_d      = 1'b1;
                        commit_half_d = wr_half_q;
                        commit_len_d  = next_cnt;
                        wr_half_d     = ~wr_half_q;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
            end
        end else begin
            case (state_q)
                SYNC: if (vlast) state_d = IDLE;
                IDLE: if (bus.rx_valid_in) begin
                    state_d  = bus.rx_last_in ? IDLE : DROP;
                    drop_inc = bus.rx_last_in;
                end
                DROP: if (vlast) begin
                    state_d  = IDLE;
                    drop_inc = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        full_d = full_q & ~bus.release_in;
        len0_d = len0_q;
        len1_d = len1_q;
        // Commit is applied after the release so it wins on the same half.
        if (commit_q) begin
            full_d[commit_half_q] = 1'b1;
            if (commit_half_q) len1_d = commit_len_q;
            else               len0_d = commit_len_q;
        end
        drop_d = (drop_inc && (drop_q != '1)) ? drop_q + 16'd1 : drop_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= SYNC;
            count_q       <= '0;
            wr_half_q     <= 1'b0;
            full_q        <= '0;
            len0_q        <= '0;
            len1_q        <= '0;
            drop_q        <= '0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            commit_q      <= 1'b0;
            commit_half_q <= 1'b0;
            commit_len_q  <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            wr_half_q     <= wr_half_d;
            full_q        <= full_d;
            len0_q        <= len0_d;
            len1_q        <= len1_d;
            drop_q        <= drop_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            commit_q      <= commit_d;
            commit_half_q <= commit_half_d;
            commit_len_q  <= commit_len_d;
        end
    end

    assign bus.bram_en_out   = we_q;
    assign bus.bram_we_out   = we_q;
    assign bus.bram_addr_out = addr_q;
    assign bus.bram_d_out    = data_q;
    assign bus.full_out      = full_q;
    assign bus.len0_out      = len0_q;
    assign bus.len1_out      = len1_q;
    assign bus.drop_cnt_out  = drop_q;

endmodule

// File: tb/tb_eth_rx_pkt_writer.sv
// Self-checking bench for eth_rx_pkt_writer: frame table plus hand-written
// back-to-back, release/commit, max-length and mid-frame reset sequences.
module tb_eth_rx_pkt_writer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    eth_rx_pkt_writer_if bus ();

    eth_rx_pkt_writer #(.HALF_BYTES(4096), .MIN_LEN(14)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    typedef struct {
        int          len;
        int          err_pos;
        logic [1:0]  rel;
        logic        half;
        bit          wr;
        logic [1:0]  full;
        logic [12:0] len0;
        logic [12:0] len1;
        logic [15:0] drop;
    } vec_t;

    vec_t        tbl [9];
    int          checks = 0;
    int          errors = 0;
    logic [20:0] exp_q [$];
    logic [20:0] mon_e;
    logic [1:0]  prev_full;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int len, input int err_pos, input logic half,
                              input bit wr, input logic [7:0] seed);
        for (int i = 0; i < len; i++) begin
            logic [7:0] b;
            b = 8'(i * 7) + seed;
            bus.rx_d_in     = b;
            bus.rx_valid_in = 1'b1;
            bus.rx_last_in  = (i == len - 1);
            bus.rx_err_in   = (i == err_pos);
            if (wr && i < 4096 && (err_pos < 0 || i < err_pos))
                exp_q.push_back({half, 12'(i), b});
            tick();
        end
        bus.rx_valid_in = 1'b0;
        bus.rx_last_in  = 1'b0;
        bus.rx_err_in   = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic [1:0] full,
                                input logic [12:0] l0, input logic [12:0] l1,
                                input logic [15:0] drop);
        chk({tag, "_full"}, 32'(bus.full_out), 32'(full));
        chk({tag, "_len0"}, 32'(bus.len0_out), 32'(l0));
        chk({tag, "_len1"}, 32'(bus.len1_out), 32'(l1));
        chk({tag, "_drop"}, 32'(bus.drop_cnt_out), 32'(drop));
        chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_release(input logic [1:0] rel);
        bus.release_in = rel;
        tick();
        bus.release_in = 2'b00;
    endtask

    // Scoreboard: every BRAM write must match the next expected {addr, data}.
    always @(negedge clk) begin
        if (bus.bram_we_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                         bus.bram_addr_out, bus.bram_d_out);
            end else begin
                mon_e = exp_q.pop_front();
                chk("bram_write", 32'({bus.bram_addr_out, bus.bram_d_out}), 32'(mon_e));
                chk("bram_en", 32'(bus.bram_en_out), 32'd1);
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got no finish, expected finish before 5ms");
        $fatal(1, "watchdog");
    end

    initial begin
        //           len  err  rel    half  wr  full   len0     len1     drop
        tbl[0] = '{   1,  -1, 2'b00, 1'b0, 1'b0, 2'b00, 13'd0,   13'd0,   16'd0};
        tbl[1] = '{  60,  -1, 2'b00, 1'b0, 1'b1, 2'b01, 13'd60,  13'd0,   16'd0};
        tbl[2] = '{  64,  -1, 2'b00, 1'b1, 1'b1, 2'b11, 13'd60,  13'd64,  16'd0};
        tbl[3] = '{  64,  -1, 2'b00, 1'b0, 1'b0, 2'b11, 13'd60,  13'd64,  16'd1};
        tbl[4] = '{ 100,  -1, 2'b01, 1'b0, 1'b1, 2'b11, 13'd100, 13'd64,  16'd1};
        tbl[5] = '{  60,  30, 2'b10, 1'b1, 1'b1, 2'b01, 13'd100, 13'd64,  16'd2};
        tbl[6] = '{  10,  -1, 2'b00, 1'b1, 1'b1, 2'b01, 13'd100, 13'd64,  16'd3};
        tbl[7] = '{  14,  -1, 2'b00, 1'b1, 1'b1, 2'b11, 13'd100, 13'd14,  16'd3};
        tbl[8] = '{  13,  -1, 2'b11, 1'b0, 1'b1, 2'b00, 13'd100, 13'd14,  16'd4};

        bus.rx_d_in     = '0;
        bus.rx_valid_in = 1'b0;
        bus.rx_last_in  = 1'b0;
        bus.rx_err_in   = 1'b0;
        bus.release_in  = 2'b00;
        rst = 1'b1;
        repeat (3) tick();
        check_status("reset", 2'b00, 13'd0, 13'd0, 16'd0);
        chk("reset_en", 32'(bus.bram_en_out), 32'd0);
        chk("reset_we", 32'(bus.bram_we_out), 32'd0);
        chk("reset_addr", 32'(bus.bram_addr_out), 32'd0);
        chk("reset_data", 32'(bus.bram_d_out), 32'd0);
        rst = 1'b0;
        tick();

        prev_full = 2'b00;
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].rel != 2'b00) pulse_release(tbl[i].rel);
            send_frame(tbl[i].len, tbl[i].err_pos, tbl[i].half, tbl[i].wr, 8'(i * 16 + 3));
            chk($sformatf("vec%0d_full_latency", i), 32'(bus.full_out),
                32'(prev_full & ~tbl[i].rel));
            tick();
            tick();
            check_status($sformatf("vec%0d", i), tbl[i].full, tbl[i].len0, tbl[i].len1,
                         tbl[i].drop);
            prev_full = tbl[i].full;
        end

        // Three back-to-back frames: halves 0 and 1 commit, third is dropped.
        send_frame(64, -1, 1'b0, 1'b1, 8'h11);
        send_frame(64, -1, 1'b1, 1'b1, 8'h22);
        send_frame(64, -1, 1'b0, 1'b0, 8'h33);
        tick();
        tick();
        check_status("b2b", 2'b11, 13'd64, 13'd64, 16'd5);

        // Release of half 1 in the same cycle half 0 commits.
        pulse_release(2'b01);
        chk("rel0_full", 32'(bus.full_out), 32'b10);
        send_frame(100, -1, 1'b0, 1'b1, 8'h44);
        bus.release_in = 2'b10;
        tick();
        bus.release_in = 2'b00;
        check_status("rel_commit", 2'b01, 13'd100, 13'd64, 16'd5);

        // Maximum-length frame, then one byte too many.
        send_frame(4096, -1, 1'b1, 1'b1, 8'h55);
        tick();
        tick();
        check_status("max_len", 2'b11, 13'd100, 13'd4096, 16'd5);
        pulse_release(2'b11);
        send_frame(4097, -1, 1'b0, 1'b1, 8'h66);
        tick();
        tick();
        check_status("overflow", 2'b00, 13'd100, 13'd4096, 16'd6);

        // Reset asserted on byte 20 of a 50-byte frame.
        for (int i = 0; i < 50; i++) begin
            logic [7:0] b;
            if (i == 21) begin
                check_status("midrst", 2'b00, 13'd0, 13'd0, 16'd0);
                chk("midrst_en", 32'(bus.bram_en_out), 32'd0);
                chk("midrst_addr", 32'(bus.bram_addr_out), 32'd0);
                chk("midrst_data", 32'(bus.bram_d_out), 32'd0);
            end
            b = 8'(i) + 8'h70;
            rst = (i == 20);
            bus.rx_d_in     = b;
            bus.rx_valid_in = 1'b1;
            bus.rx_last_in  = (i == 49);
            bus.rx_err_in   = 1'b0;
            if (i < 20) exp_q.push_back({1'b0, 12'(i), b});
            tick();
        end
        rst = 1'b0;
        bus.rx_valid_in = 1'b0;
        bus.rx_last_in  = 1'b0;
        send_frame(30, -1, 1'b0, 1'b1, 8'h77);
        tick();
        tick();
        check_status("after_rst", 2'b01, 13'd30, 13'd0, 16'd0);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
